// File: rtl/regfile_pkg.sv
// Shared constants for the parametrised MIPS register file and its benches.
// Holds the default geometry and the conventional register indices.
package regfile_pkg;

    localparam int DEF_DW   = 32;
    localparam int DEF_NREG = 32;
    localparam int DEF_NRD  = 2;

    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 29;
    localparam int REG_RA   = 31;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits marking in-flight loads, with set-over-clear priority
// and a same-cycle clear bypass on the per-port busy lookup.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG     = DEF_NREG,
    parameter int AW       = $clog2(NREG),
    parameter int NRD      = DEF_NRD,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_addr,
    output logic [NRD-1:0]    rd_busy,
    output logic              busy_any
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            iss_eff;

    assign iss_eff = iss_en && !((ZERO_REG != 0) && (iss_addr == AW'(REG_ZERO)));

    // A new producer supersedes the returning load, so the set is applied last.
    always_comb begin
        // NOTE: defaulting busy_d to the current state before any conditional
        // update keeps every path assigned, so no latch is inferred.
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (iss_eff) begin
            busy_d[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers take non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of block evaluation order.
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_any = |busy_q;

    for (genvar k = 0; k < NRD; k++) begin : g_port
        logic [AW-1:0] ra;
        logic          bsy;

        assign ra = rd_addr[k*AW +: AW];

        always_comb begin
            bsy = busy_q[ra];
            if ((BYPASS != 0) && clr_en && (clr_addr == ra) && !(iss_eff && (iss_addr == ra))) begin
                bsy = 1'b0;
            end
            if ((ZERO_REG != 0) && (ra == AW'(REG_ZERO))) begin
                bsy = 1'b0;
            end
        end

        assign rd_busy[k] = bsy;
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read, dual-write register file: ALU writeback (port 0),
// load return (port 1, wins on collision), optional bypass and busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int NREG     = DEF_NREG,
    parameter int AW       = $clog2(NREG),  // derived from NREG
    parameter int NRD      = DEF_NRD,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              wr0_en,
    input  logic [AW-1:0]     wr0_addr,
    input  logic [DW-1:0]     wr0_data,
    input  logic              wr1_en,
    input  logic [AW-1:0]     wr1_addr,
    input  logic [DW-1:0]     wr1_data,
    input  logic              wr1_clr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    output logic              busy_any
);

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];
    logic          we0;
    logic          we1;

    assign we0 = wr0_en && !((ZERO_REG != 0) && (wr0_addr == AW'(REG_ZERO)));
    assign we1 = wr1_en && !((ZERO_REG != 0) && (wr1_addr == AW'(REG_ZERO)));

    // Port 1 is applied second so a same-address collision keeps the load data.
    always_comb begin
        regs_d = regs_q;
        if (we0) begin
            regs_d[wr0_addr] = wr0_data;
        end
        if (we1) begin
            regs_d[wr1_addr] = wr1_data;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the array is reset explicitly because architectural state must
        // read zero after reset; this keeps it in flops rather than RAM macros.
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic [DW-1:0] word;

        assign ra = rd_addr[k*AW +: AW];

        always_comb begin
            word = regs_q[ra];
            if (BYPASS != 0) begin
                if (we1 && (wr1_addr == ra)) begin
                    word = wr1_data;
                end else if (we0 && (wr0_addr == ra)) begin
                    word = wr0_data;
                end
            end
            if ((ZERO_REG != 0) && (ra == AW'(REG_ZERO))) begin
                word = '0;
            end
        end

        assign rd_data[k*DW +: DW] = word;
    end

    regfile_scoreboard #(
        .NREG     (NREG),
        .AW       (AW),
        .NRD      (NRD),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .clr_en   (we1 && wr1_clr),
        .clr_addr (wr1_addr),
        .rd_busy  (rd_busy),
        .busy_any (busy_any)
    );

endmodule
